// File: rtl/dmx512_rx.sv
// rtl/dmx512_rx.sv - DMX512 receiver: break/MAB framing, 250 kbaud slot decode, 512-channel store
// Optional DMX_RX_SC_FILTER_EN: only packets whose start code is 0x00 write channel memory.
module dmx512_rx #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dmx_in,
  input  logic [9:0] read_addr,
  output logic [7:0] read_data,
  output logic [7:0] start_code,
  output logic [9:0] slot_count,
  output logic       packet_done,
  output logic       frame_err
);
  localparam int          CPU     = CLK_HZ / 1000000;
  localparam logic [12:0] T_BREAK = 13'(88 * CPU);
  localparam logic [12:0] T_MAB   = 13'(8 * CPU);
  localparam logic [12:0] T_BIT   = 13'(4 * CPU);
  localparam logic [12:0] T_HALF  = 13'(2 * CPU);
  // Stop-sample offsets from the start-bit edge, so a break beginning at a slot keeps its age
  localparam logic [12:0] T_PRE1  = T_HALF + 13'd9 * T_BIT;
  localparam logic [12:0] T_PRE2  = T_PRE1 + T_BIT;

  typedef enum logic [2:0] {IDLE, BREAK, MAB, START, DATA, STOP, INTERSLOT} state_t;

  state_t      state, state_next;
  logic [1:0]  sync;
  logic        rx;
  logic [12:0] timer, timer_next;
  logic [2:0]  bit_cnt, bit_next;
  logic [7:0]  shreg;
  logic [9:0]  slot_idx;
  logic        pending, commit, wr_ok;
  logic        shift_en, commit_set, ferr_set, done_brk, slot_clr;
  logic [7:0]  mem [1:512];

  assign rx = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= 13'd0;
      bit_cnt <= 3'd0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_cnt <= bit_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = (timer == 13'h1FFF) ? timer : timer + 13'd1;
    bit_next   = bit_cnt;
    shift_en   = 1'b0;
    commit_set = 1'b0;
    ferr_set   = 1'b0;
    done_brk   = 1'b0;
    slot_clr   = 1'b0;
    unique case (state)
      IDLE: if (!rx) begin
        state_next = BREAK;
        timer_next = 13'd0;
      end
      BREAK: begin
        done_brk = (timer == T_BREAK) && pending;
        if (rx) begin
          state_next = (timer >= T_BREAK) ? MAB : IDLE;
          timer_next = 13'd0;
        end
      end
      MAB: if (!rx) begin
        state_next = (timer >= T_MAB) ? START : IDLE;
        slot_clr   = (timer >= T_MAB);
        timer_next = 13'd0;
      end
      START: if (timer == T_HALF) begin
        state_next = rx ? IDLE : DATA;
        timer_next = 13'd0;
        bit_next   = 3'd0;
      end
      DATA: if (timer == T_BIT - 13'd1) begin
        timer_next = 13'd0;
        shift_en   = 1'b1;
        bit_next   = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          state_next = STOP;
          bit_next   = 3'd0;
        end
      end
      STOP: if (timer == T_BIT - 13'd1) begin
        timer_next = 13'd0;
        if (!rx) begin
          ferr_set   = 1'b1;
          state_next = BREAK;
          timer_next = bit_cnt[0] ? T_PRE2 : T_PRE1;
        end else if (bit_cnt[0]) begin
          commit_set = 1'b1;
          state_next = (slot_idx == 10'd512) ? IDLE : INTERSLOT;
        end else begin
          bit_next = 3'd1;
        end
      end
      INTERSLOT: if (!rx) begin
        state_next = START;
        timer_next = 13'd0;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DMX_RX_SC_FILTER_EN
  logic sc_ok;
  always_ff @(posedge clk) begin
    if (rst) sc_ok <= 1'b0;
    else if (commit && slot_idx == 10'd0) sc_ok <= (shreg == 8'h00);
  end
  assign wr_ok = sc_ok;
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= 2'b11;
      shreg       <= 8'h00;
      slot_idx    <= 10'd0;
      pending     <= 1'b0;
      commit      <= 1'b0;
      start_code  <= 8'h00;
      slot_count  <= 10'd0;
      packet_done <= 1'b0;
      frame_err   <= 1'b0;
      read_data   <= 8'h00;
      for (int i = 1; i <= 512; i++) mem[i] <= 8'h00;
    end else begin
      sync        <= {sync[0], dmx_in};
      frame_err   <= ferr_set;
      commit      <= commit_set;
      packet_done <= 1'b0;
      if (shift_en) shreg <= {rx, shreg[7:1]};
      if (slot_clr) slot_idx <= 10'd0;
      if (done_brk) begin
        packet_done <= 1'b1;
        slot_count  <= slot_idx;
        pending     <= 1'b0;
      end
      // Byte lands one cycle after its second stop sample
      if (commit) begin
        if (slot_idx == 10'd0) start_code <= shreg;
        else if (slot_idx <= 10'd512 && wr_ok) mem[slot_idx] <= shreg;
        slot_idx <= slot_idx + 10'd1;
        pending  <= 1'b1;
        if (slot_idx == 10'd512) begin
          packet_done <= 1'b1;
          slot_count  <= 10'd513;
          pending     <= 1'b0;
        end
      end
      if (read_addr != 10'd0 && read_addr <= 10'd512) read_data <= mem[read_addr];
      else read_data <= 8'h00;
    end
  end
endmodule

// File: tb/tb_dmx512_rx.sv
// tb/tb_dmx512_rx.sv - self-checking bench for dmx512_rx with a packet-level reference model
// Runs the DUT at CLK_HZ = 1 MHz so one microsecond is one clock and a 513-slot packet stays short.
module tb_dmx512_rx;
  localparam int CLK_HZ  = 1000000;
  localparam int US      = CLK_HZ / 1000000;
  localparam int BIT     = 4 * US;
  localparam int BRK_MIN = 88 * US;
  localparam int MAB_MIN = 8 * US;
`ifdef DMX_RX_SC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, dmx_in = 1'b1;
  logic [9:0] read_addr = 10'd0;
  logic [7:0] read_data, start_code;
  logic [9:0] slot_count;
  logic       packet_done, frame_err;

  dmx512_rx #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .dmx_in(dmx_in), .read_addr(read_addr),
    .read_data(read_data), .start_code(start_code), .slot_count(slot_count),
    .packet_done(packet_done), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int n_tot = 0, n_pass = 0, cyc = 0;
  int done_seen = 0, ferr_seen = 0, last_done_cyc = 0, brk_cyc = 0;
  bit quiet = 1'b0, quiet_d = 1'b0;
  logic [9:0] addr_d = 10'd0;

  logic [7:0] m_mem [0:512];
  logic [7:0] m_sc = 8'h00;
  bit m_scok = 1'b0, m_live = 1'b0, m_in_frame = 1'b0, m_pending = 1'b0;
  int m_slot = 0, m_slot_count = 0, m_exp_slots = 0, m_done_exp = 0, m_ferr_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int model_rd(input int a);
    return (a >= 1 && a <= 512) ? int'(m_mem[a]) : 0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (packet_done === 1'b1) begin
        done_seen++;
        last_done_cyc = cyc;
        chk("done_slot_count", int'(slot_count), m_exp_slots);
        chk("done_start_code", int'(start_code), int'(m_sc));
      end
      if (frame_err === 1'b1) ferr_seen++;
      if (quiet && quiet_d) begin
        chk($sformatf("rd[%0d]", addr_d), int'(read_data), model_rd(int'(addr_d)));
        chk("q_start_code", int'(start_code), int'(m_sc));
        chk("q_slot_count", int'(slot_count), m_slot_count);
        chk("q_packet_done", int'(packet_done), 0);
        chk("q_frame_err", int'(frame_err), 0);
      end
    end
    addr_d  <= read_addr;
    quiet_d <= quiet;
  end

  task automatic model_clear();
    for (int i = 0; i <= 512; i++) m_mem[i] = 8'h00;
    m_sc = 8'h00; m_scok = 1'b0; m_live = 1'b0; m_in_frame = 1'b0;
    m_pending = 1'b0; m_slot = 0; m_slot_count = 0;
  endtask

  task automatic model_commit(input logic [7:0] b);
    if (!m_live) return;
    if (m_slot == 0) begin
      m_sc = b;
      m_scok = (b == 8'h00);
    end else if (!FILT || m_scok) m_mem[m_slot] = b;
    m_slot++;
    m_pending = 1'b1;
    if (m_slot == 513) begin
      m_done_exp++; m_exp_slots = 513; m_slot_count = 513;
      m_pending = 1'b0; m_live = 1'b0; m_in_frame = 1'b0;
    end
  endtask

  task automatic line(input logic v, input int n);
    dmx_in = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // A break arriving mid-frame first looks like an all-zero slot, hence the frame error
  task automatic send_break(input int len);
    if (m_in_frame) m_ferr_exp++;
    if (len >= BRK_MIN && m_pending) begin
      m_done_exp++; m_exp_slots = m_slot; m_slot_count = m_slot; m_pending = 1'b0;
    end
    brk_cyc = cyc;
    line(1'b0, len);
    m_live = (len >= BRK_MIN);
    m_in_frame = m_live;
  endtask

  task automatic mab(input int len);
    line(1'b1, len);
    if (len < MAB_MIN) begin m_live = 1'b0; m_in_frame = 1'b0; end
    if (m_live) m_slot = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(b[i], BIT);
    if (bad) begin
      if (m_live) m_ferr_exp++;
      m_live = 1'b0; m_in_frame = 1'b0;
      line(1'b0, BIT);
      line(1'b1, BIT);
    end else begin
      line(1'b1, BIT);
      model_commit(b);
      line(1'b1, BIT);
    end
  endtask

  task automatic sweep();
    int addrs[12] = '{0, 1, 2, 3, 4, 5, 6, 255, 511, 512, 513, 1023};
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      read_addr = 10'(addrs[i]);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    quiet = 1'b0;
  endtask

  task automatic read_lit(input string name, input int a, input int exp);
    read_addr = 10'(a);
    @(posedge clk);
    @(negedge clk);
    chk(name, int'(read_data), exp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    dmx_in = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_read_data"}, int'(read_data), 0);
    chk({tag, "_start_code"}, int'(start_code), 0);
    chk({tag, "_slot_count"}, int'(slot_count), 0);
    chk({tag, "_packet_done"}, int'(packet_done), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, f0, lat;
    model_clear();
    read_addr = 10'd1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");
    sweep();

    // Full 513-slot packet
    send_break(100 * US); mab(12 * US);
    send_byte(8'h00, 1'b0); send_byte(8'h11, 1'b0);
    for (int i = 2; i <= 511; i++) send_byte(8'(i) ^ 8'h3C, 1'b0);
    send_byte(8'hA5, 1'b0);
    idle_cycles(20);
    chk("full_done_count", done_seen, 1);
    chk("full_slot_count", int'(slot_count), 513);
    read_lit("full_ch1", 1, 8'h11);
    read_lit("full_ch512", 512, 8'hA5);
    sweep();

    // Truncated packet: SC + 3 channels, then a break
    send_break(100 * US); mab(12 * US);
    send_byte(8'h00, 1'b0); send_byte(8'h21, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h23, 1'b0);
    send_break(100 * US); mab(12 * US);
    idle_cycles(10);
    lat = last_done_cyc - brk_cyc;
    n_tot++;
    if (lat >= BRK_MIN && lat <= BRK_MIN + 5) n_pass++;
    else $display("FAIL trunc_latency: got %0d cycles expected %0d..%0d", lat, BRK_MIN, BRK_MIN + 5);
    chk("trunc_slot_count", int'(slot_count), 4);
    read_lit("trunc_ch3", 3, 8'h23);
    read_lit("trunc_ch4", 4, 8'h38);
    sweep();

    // Short break then a frame: ignored; a following real packet is received
    d0 = done_seen;
    send_break(80 * US); mab(12 * US);
    send_byte(8'h00, 1'b0); send_byte(8'h77, 1'b0);
    idle_cycles(20);
    chk("short_no_done", done_seen - d0, 0);
    read_lit("short_ch1", 1, 8'h21);
    send_break(100 * US); mab(12 * US);
    send_byte(8'h00, 1'b0); send_byte(8'h66, 1'b0);
    send_break(100 * US); mab(12 * US);
    idle_cycles(10);
    read_lit("after_short_ch1", 1, 8'h66);
    chk("after_short_slot_count", int'(slot_count), 2);

    // Bad stop bit on slot 5
    send_break(100 * US); mab(12 * US);
    send_byte(8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) send_byte(8'h40 + 8'(i), 1'b0);
    d0 = done_seen; f0 = ferr_seen;
    send_byte(8'h99, 1'b1);
    idle_cycles(200);
    chk("badstop_ferr_pulses", ferr_seen - f0, 1);
    chk("badstop_no_done", done_seen - d0, 0);
    read_lit("badstop_ch5", 5, 8'h39);
    read_lit("badstop_ch4", 4, 8'h44);
    sweep();

    // Non-zero start code
    do_reset();
    send_break(100 * US); mab(12 * US);
    send_byte(8'h17, 1'b0); send_byte(8'h55, 1'b0);
    send_break(100 * US); mab(12 * US);
    idle_cycles(10);
    chk("sc17_start_code", int'(start_code), 8'h17);
    read_lit("sc17_ch1", 1, FILT ? 0 : 8'h55);
    sweep();

    // Reset during the data bits of slot 2
    send_break(100 * US); mab(12 * US);
    send_byte(8'h00, 1'b0); send_byte(8'h12, 1'b0);
    line(1'b0, BIT); line(1'b1, BIT); line(1'b0, BIT); line(1'b1, BIT);
    d0 = done_seen;
    do_reset();
    check_zero("midreset");
    idle_cycles(100);
    chk("midreset_no_done", done_seen - d0, 0);
    sweep();
    send_break(100 * US); mab(12 * US);
    send_byte(8'h00, 1'b0); send_byte(8'hC1, 1'b0); send_byte(8'hC2, 1'b0); send_byte(8'hC3, 1'b0);
    send_break(100 * US); mab(12 * US);
    idle_cycles(10);
    read_lit("post_reset_ch2", 2, 8'hC2);
    chk("post_reset_slot_count", int'(slot_count), 4);
    sweep();

    chk("total_packet_done", done_seen, m_done_exp);
    chk("total_frame_err", ferr_seen, m_ferr_exp);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  task automatic idle_cycles(input int n);
    line(1'b1, n);
  endtask
endmodule

// File: doc/dmx512_rx.md
DMX512_RX -- requirements
Module: dmx512_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000; timing constants below assume this value.
REQ-002 SHALL have clk input, width 1: single system clock, 50 MHz.
REQ-003 SHALL have rst input, width 1: reset, synchronous and active-high.
REQ-004 SHALL have dmx_in input, width 1: asynchronous line from the RS-485 receiver; idle/mark is 1.
REQ-005 SHALL have read_addr input, width 10: channel to read, valid range 1..512.
REQ-006 SHALL have read_data output, width 8: registered channel value for read_addr.
REQ-007 SHALL have start_code output, width 8: start code of the last accepted packet.
REQ-008 SHALL have slot_count output, width 10: slots received in the last completed packet, start code included (1..513).
REQ-009 SHALL have packet_done output, width 1: one-cycle pulse when a packet completes.
REQ-010 SHALL have frame_err output, width 1: one-cycle pulse when a stop bit is sampled as 0.

Function
REQ-011 SHALL pass dmx_in through a 2-flop synchronizer; all logic below uses the synchronized signal rx.
REQ-012 SHALL use a 13-bit timer that saturates at 8191 and is zeroed on every state transition unless stated otherwise.
REQ-013 SHALL implement the states IDLE, BREAK, MAB, START, DATA, STOP and INTERSLOT.
REQ-014 IDLE: on rx=0, SHALL go to BREAK.
REQ-015 BREAK: on rx=1 with timer<4400 (88 us), SHALL go to IDLE and the break is ignored; on rx=1 with timer>=4400, SHALL go to MAB.
REQ-016 On the first cycle timer reaches 4400 in BREAK with at least one slot received since the previous packet_done, SHALL pulse packet_done and latch slot_count.
REQ-017 MAB: on rx=0 with timer<400 (8 us), SHALL go to IDLE; on rx=0 with timer>=400, SHALL go to START with slot index 0.
REQ-018 START: at timer=100 (mid start bit), SHALL sample rx; rx=0 goes to DATA, rx=1 (glitch) goes to IDLE with no error.
REQ-019 DATA: SHALL sample every 200 cycles, for 8 bits, LSB first, into a shift register.
REQ-020 STOP: SHALL sample 2 bits at 200-cycle spacing.
REQ-021 If either stop bit is 0, SHALL pulse frame_err, discard the byte, and go to BREAK with the timer preloaded to 1900 (first stop bit) or 2100 (second stop bit), so that a break starting inside a slot still qualifies.
REQ-022 When both stop bits are 1, SHALL commit the byte in the cycle after the second stop sample: slot 0 goes to start_code; slots 1..512 go to channel memory[slot].
REQ-023 After commit, SHALL increment the slot index; if the committed slot was 512, SHALL pulse packet_done, latch slot_count=513 and go to IDLE; otherwise SHALL go to INTERSLOT.
REQ-024 INTERSLOT: on rx=0, SHALL go to START with timer 0; there SHALL be no mark-time timeout.
REQ-025 Slot index SHALL be 10 bits and SHALL never write beyond 512.
REQ-026 Read port latency SHALL be 1 cycle: read_data = memory[read_addr] registered.
REQ-027 read_addr of 0 or >512 SHALL return 0.
REQ-028 A read and a commit to the same channel in the same cycle SHALL return the old value.
REQ-029 A packet truncated by a new break SHALL keep channels beyond the truncation point at their prior values.

Reset
REQ-030 On rst=1 at a clk edge, SHALL enter IDLE, zero the timer, slot index and shift register, and set both synchronizer flops to 1.
REQ-031 On reset, SHALL drive read_data=0, start_code=0, slot_count=0, packet_done=0 and frame_err=0, and clear all 512 channels to 0.
REQ-032 Reset asserted mid-slot SHALL discard the partial byte and SHALL NOT pulse packet_done.

Configuration
REQ-033 With DMX_RX_SC_FILTER_EN defined: if slot 0 is not 0x00, start_code SHALL still update but slots 1..512 of that packet SHALL NOT write memory; packet_done and slot_count SHALL behave unchanged.
REQ-034 Without DMX_RX_SC_FILTER_EN: every packet writes memory regardless of start code.

Verification
REQ-035 Full packet: 100 us break, 12 us MAB, SC=0x00, ch1=0x11, ch512=0xA5 -> single packet_done, slot_count=513, read ch1 gives 0x11 and ch512 gives 0xA5 one cycle after read_addr is applied.
REQ-036 Short break: 80 us low, then a valid frame -> no slot stored and no packet_done; a following valid break/packet is received normally.
REQ-037 Truncated packet: SC plus 3 channels, then a 100 us break -> packet_done 4400 cycles after the break falling edge, slot_count=4, ch4 unchanged.
REQ-038 Bad stop bit: slot 5 with stop bit forced to 0 for one bit time -> one frame_err pulse, ch5 keeps its old value, no packet_done.
REQ-039 Start code 0x17 with ch1=0x55, run with the macro defined and undefined -> start_code=0x17 in both; ch1 stays 0 when the macro is defined and becomes 0x55 when undefined.
REQ-040 Reset pulse during the DATA bits of slot 2 -> all outputs 0 the next cycle, and a subsequent full packet is received correctly.
